// File: rtl/alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// alu_issue_ctrl
//
// Driving end of the ALU interface in the multicycle datapath. Accepts an op
// request over a valid/ready handshake, decodes aluOp/funct into the 4-bit
// ALU control code, drives the combinational ALU for one ISSUE cycle, then
// captures the result and zero flag (and resolves beq/bne) and holds them on
// a valid/ready response channel until consumed.
//
// Ports:
//   clk, reset               clock; asynchronous active-high reset
//   reqValid/reqReady        request handshake
//   reqAluOp, reqFunct       op select (00 add, 01 sub, 10 R-type, 11 or)
//   reqBranch, reqBne        conditional branch flag and beq/bne select
//   reqA, reqB               operands
//   aluCtr, aluIn1, aluIn2   to the ALU (meaningful only during ISSUE)
//   aluRes, aluZero          from the ALU
//   resValid/resReady        response handshake
//   resData, resZero         captured ALU result and zero flag
//   branchTaken              branch outcome captured with the result
//   illegalOp                unsupported op trap flag
//
// Optional feature: define ALU_ILLEGAL_TRAP_EN to trap unsupported R-type
// funct codes (and R-type ops flagged as branches). Trapped ops skip ISSUE
// and respond with zero data and illegalOp=1. Without the macro illegalOp is
// tied low and unsupported functs issue control code 1111 to the ALU.
// ---------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             reqValid,
    output logic             reqReady,
    input  logic [1:0]       reqAluOp,
    input  logic [5:0]       reqFunct,
    input  logic             reqBranch,
    input  logic             reqBne,
    input  logic [WIDTH-1:0] reqA,
    input  logic [WIDTH-1:0] reqB,
    output logic [3:0]       aluCtr,
    output logic [WIDTH-1:0] aluIn1,
    output logic [WIDTH-1:0] aluIn2,
    input  logic [WIDTH-1:0] aluRes,
    input  logic             aluZero,
    output logic             resValid,
    input  logic             resReady,
    output logic [WIDTH-1:0] resData,
    output logic             resZero,
    output logic             branchTaken,
    output logic             illegalOp
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       ctr_q, ctr_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             branch_q, branch_d;
    logic             bne_q, bne_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_zero_q, res_zero_d;
    logic             taken_q, taken_d;
    logic [3:0]       dec_ctr;
    logic             accept;

    // A response being consumed frees the slot in the same edge, which is
    // what allows back-to-back issue from RESP.
    assign reqReady = (state_q == IDLE) || ((state_q == RESP) && resReady);
    assign accept   = reqValid && reqReady;

    // 1111 is reserved for unsupported functs; the ALU returns 0 for it.
    always_comb begin
        dec_ctr = 4'b1111;
        case (reqAluOp)
            2'b00: dec_ctr = 4'b0010;
            2'b01: dec_ctr = 4'b0110;
            2'b11: dec_ctr = 4'b0001;
            default: begin
                case (reqFunct)
                    6'b100000: dec_ctr = 4'b0010;
                    6'b100010: dec_ctr = 4'b0110;
                    6'b100100: dec_ctr = 4'b0000;
                    6'b100101: dec_ctr = 4'b0001;
                    6'b101010: dec_ctr = 4'b0111;
                    6'b100111: dec_ctr = 4'b1100;
                    default:   dec_ctr = 4'b1111;
                endcase
            end
        endcase
    end

`ifdef ALU_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_d;
    logic dec_illegal;

    assign dec_illegal = (reqAluOp == 2'b10) && ((dec_ctr == 4'b1111) || reqBranch);
    assign illegalOp   = illegal_q;
`else
    assign illegalOp   = 1'b0;
`endif

    // Next-state logic. An accept is applied last so that a back-to-back
    // request arriving while RESP drains overrides the return to IDLE.
    always_comb begin
        state_d    = state_q;
        ctr_d      = ctr_q;
        a_d        = a_q;
        b_d        = b_q;
        branch_d   = branch_q;
        bne_d      = bne_q;
        res_data_d = res_data_q;
        res_zero_d = res_zero_q;
        taken_d    = taken_q;
`ifdef ALU_ILLEGAL_TRAP_EN
        illegal_d  = illegal_q;
`endif

        case (state_q)
            ISSUE: begin
                res_data_d = aluRes;
                res_zero_d = aluZero;
                taken_d    = branch_q && (bne_q ? !aluZero : aluZero);
                state_d    = RESP;
            end
            RESP: begin
                if (resReady) begin
                    state_d = IDLE;
`ifdef ALU_ILLEGAL_TRAP_EN
                    illegal_d = 1'b0;
`endif
                end
            end
            IDLE: ;
            default: state_d = IDLE;
        endcase

        if (accept) begin
`ifdef ALU_ILLEGAL_TRAP_EN
            if (dec_illegal) begin
                // Trapped ops never reach the ALU, so its inputs keep their
                // previously issued values.
                res_data_d = '0;
                res_zero_d = 1'b0;
                taken_d    = 1'b0;
                illegal_d  = 1'b1;
                state_d    = RESP;
            end else begin
`else
            begin
`endif
                ctr_d    = dec_ctr;
                a_d      = reqA;
                b_d      = reqB;
                branch_d = reqBranch;
                bne_d    = reqBne;
                state_d  = ISSUE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            ctr_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            branch_q   <= 1'b0;
            bne_q      <= 1'b0;
            res_data_q <= '0;
            res_zero_q <= 1'b0;
            taken_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctr_q      <= ctr_d;
            a_q        <= a_d;
            b_q        <= b_d;
            branch_q   <= branch_d;
            bne_q      <= bne_d;
            res_data_q <= res_data_d;
            res_zero_q <= res_zero_d;
            taken_q    <= taken_d;
        end
    end

`ifdef ALU_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`endif

    assign aluCtr      = ctr_q;
    assign aluIn1      = a_q;
    assign aluIn2      = b_q;
    assign resValid    = (state_q == RESP);
    assign resData     = res_data_q;
    assign resZero     = res_zero_q;
    assign branchTaken = taken_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_issue_ctrl
//
// Self-checking bench for alu_issue_ctrl. A behavioural ALU answers the
// DUT's ALU port; expected results come from a reference model that computes
// the operation directly from aluOp/funct/operands.
// Build with ALU_ILLEGAL_TRAP_EN defined to exercise the trap variant.
// ---------------------------------------------------------------------------
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic [1:0]  reqAluOp = '0;
    logic [5:0]  reqFunct = '0;
    logic        reqBranch = 1'b0;
    logic        reqBne = 1'b0;
    logic [31:0] reqA = '0;
    logic [31:0] reqB = '0;
    logic [3:0]  aluCtr;
    logic [31:0] aluIn1;
    logic [31:0] aluIn2;
    logic [31:0] aluRes;
    logic        aluZero;
    logic        resValid;
    logic        resReady = 1'b0;
    logic [31:0] resData;
    logic        resZero;
    logic        branchTaken;
    logic        illegalOp;

    int checks = 0;
    int errors = 0;

    alu_issue_ctrl #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .reqValid(reqValid), .reqReady(reqReady),
        .reqAluOp(reqAluOp), .reqFunct(reqFunct),
        .reqBranch(reqBranch), .reqBne(reqBne),
        .reqA(reqA), .reqB(reqB),
        .aluCtr(aluCtr), .aluIn1(aluIn1), .aluIn2(aluIn2),
        .aluRes(aluRes), .aluZero(aluZero),
        .resValid(resValid), .resReady(resReady),
        .resData(resData), .resZero(resZero),
        .branchTaken(branchTaken), .illegalOp(illegalOp)
    );

    always #5 clk = ~clk;

    // Combinational ALU sitting on the other side of the interface.
    always_comb begin
        aluRes = '0;
        case (aluCtr)
            4'b0010: aluRes = aluIn1 + aluIn2;
            4'b0110: aluRes = aluIn1 - aluIn2;
            4'b0000: aluRes = aluIn1 & aluIn2;
            4'b0001: aluRes = aluIn1 | aluIn2;
            4'b0111: aluRes = ($signed(aluIn1) < $signed(aluIn2)) ? 32'd1 : 32'd0;
            4'b1100: aluRes = ~(aluIn1 | aluIn2);
            default: aluRes = '0;
        endcase
    end
    assign aluZero = (aluRes == 32'd0);

    // Reference: what the requester should see for a given request.
    function automatic void ref_model(
        input  logic [1:0]  op,
        input  logic [5:0]  fn,
        input  logic        br,
        input  logic        bne,
        input  logic [31:0] a,
        input  logic [31:0] b,
        output logic [31:0] res,
        output logic        zero,
        output logic        taken,
        output logic        ill,
        output logic [3:0]  ctr
    );
        logic unsupported;
        unsupported = 1'b0;
        res = '0;
        ctr = 4'b1111;
        if (op == 2'b00) begin res = a + b; ctr = 4'b0010; end
        else if (op == 2'b01) begin res = a - b; ctr = 4'b0110; end
        else if (op == 2'b11) begin res = a | b; ctr = 4'b0001; end
        else if (fn == 6'd32) begin res = a + b; ctr = 4'b0010; end
        else if (fn == 6'd34) begin res = a - b; ctr = 4'b0110; end
        else if (fn == 6'd36) begin res = a & b; ctr = 4'b0000; end
        else if (fn == 6'd37) begin res = a | b; ctr = 4'b0001; end
        else if (fn == 6'd42) begin res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; ctr = 4'b0111; end
        else if (fn == 6'd39) begin res = ~(a | b); ctr = 4'b1100; end
        else unsupported = 1'b1;
        zero = (res == 32'd0);
        taken = br && (bne ? !zero : zero);
`ifdef ALU_ILLEGAL_TRAP_EN
        ill = (op == 2'b10) && (unsupported || br);
`else
        ill = 1'b0;
`endif
        if (ill) begin
            res = '0;
            zero = 1'b0;
            taken = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic [1:0] op, input logic [5:0] fn, input logic br,
                             input logic bne, input logic [31:0] a, input logic [31:0] b);
        reqAluOp = op; reqFunct = fn; reqBranch = br; reqBne = bne; reqA = a; reqB = b;
        reqValid = 1'b1;
    endtask

    task automatic handshake();
        resReady = 1'b1;
        tick();
        resReady = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if ({reqReady, resValid, aluCtr, aluIn1, aluIn2, resData, resZero, branchTaken, illegalOp}
            !== {1'b1, 1'b0, 4'b0, 32'b0, 32'b0, 32'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got rdy=%b val=%b ctr=%h in1=%h in2=%h data=%h z=%b bt=%b ill=%b expected rdy=1 others 0",
                     reqReady, resValid, aluCtr, aluIn1, aluIn2, resData, resZero, branchTaken, illegalOp);
        end
    endtask

    task automatic test_rtype_add();
        drive_req(2'b10, 6'b100000, 1'b0, 1'b0, 32'd5, 32'd7);
        tick();
        reqValid = 1'b0;
        checks++;
        if ({resValid, aluCtr, aluIn1, aluIn2} !== {1'b0, 4'b0010, 32'd5, 32'd7}) begin
            errors++;
            $display("[TB] FAIL add_issue: got val=%b ctr=%b in1=%h in2=%h expected 0 0010 5 7",
                     resValid, aluCtr, aluIn1, aluIn2);
        end
        tick();
        checks++;
        if ({resValid, resData, resZero, branchTaken} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL add_result: got val=%b data=%h z=%b bt=%b expected 1 0000000c 0 0",
                     resValid, resData, resZero, branchTaken);
        end
        handshake();
        checks++;
        if ({resValid, reqReady} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL add_drain: got val=%b rdy=%b expected 0 1", resValid, reqReady);
        end
    endtask

    task automatic test_slt();
        drive_req(2'b10, 6'b101010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
        tick();
        reqValid = 1'b0;
        checks++;
        if (aluCtr !== 4'b0111) begin
            errors++;
            $display("[TB] FAIL slt_ctr: got %b expected 0111", aluCtr);
        end
        tick();
        checks++;
        if ({resValid, resData} !== {1'b1, 32'd1}) begin
            errors++;
            $display("[TB] FAIL slt_result: got val=%b data=%h expected 1 00000001", resValid, resData);
        end
        handshake();
    endtask

    task automatic test_branch();
        for (int bne = 0; bne < 2; bne++) begin
            drive_req(2'b01, 6'd0, 1'b1, 1'(bne), 32'h10, 32'h10);
            tick();
            reqValid = 1'b0;
            tick();
            checks++;
            if ({resValid, resZero, branchTaken} !== {1'b1, 1'b1, 1'(bne == 0)}) begin
                errors++;
                $display("[TB] FAIL branch_bne%0d: got val=%b z=%b bt=%b expected 1 1 %b",
                         bne, resValid, resZero, branchTaken, 1'(bne == 0));
            end
            handshake();
        end
    endtask

    task automatic test_backpressure();
        drive_req(2'b01, 6'd0, 1'b0, 1'b0, 32'd9, 32'd2);
        tick();
        // Offer a NOR request while the response is stalled; it must wait.
        drive_req(2'b10, 6'b100111, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({resValid, resData, reqReady} !== {1'b1, 32'd7, 1'b0}) begin
                errors++;
                $display("[TB] FAIL stall_hold%0d: got val=%b data=%h rdy=%b expected 1 00000007 0",
                         i, resValid, resData, reqReady);
            end
            tick();
        end
        resReady = 1'b1;
        #1;
        checks++;
        if (reqReady !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_ready: got %b expected 1", reqReady);
        end
        tick();
        resReady = 1'b0;
        reqValid = 1'b0;
        checks++;
        if ({resValid, aluCtr} !== {1'b0, 4'b1100}) begin
            errors++;
            $display("[TB] FAIL b2b_issue: got val=%b ctr=%b expected 0 1100", resValid, aluCtr);
        end
        tick();
        checks++;
        if ({resValid, resData, resZero} !== {1'b1, 32'hFFFF_FFFF, 1'b0}) begin
            errors++;
            $display("[TB] FAIL b2b_result: got val=%b data=%h z=%b expected 1 ffffffff 0",
                     resValid, resData, resZero);
        end
        handshake();
    endtask

    task automatic test_reset_mid();
        drive_req(2'b00, 6'd0, 1'b0, 1'b0, 32'd100, 32'd23);
        tick();
        reqValid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({resValid, reqReady, aluCtr, aluIn1} !== {1'b0, 1'b1, 4'b0, 32'b0}) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got val=%b rdy=%b ctr=%b in1=%h expected 0 1 0 0",
                     resValid, reqReady, aluCtr, aluIn1);
        end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (resValid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL midreset_noresult%0d: got val=%b expected 0", i, resValid);
            end
        end
    endtask

    task automatic test_illegal();
        drive_req(2'b10, 6'b000000, 1'b0, 1'b0, 32'd3, 32'd4);
        tick();
        reqValid = 1'b0;
`ifdef ALU_ILLEGAL_TRAP_EN
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({resValid, illegalOp, resData, resZero, branchTaken} !== {1'b1, 1'b1, 32'd0, 1'b0, 1'b0}) begin
                errors++;
                $display("[TB] FAIL illegal_trap%0d: got val=%b ill=%b data=%h z=%b bt=%b expected 1 1 0 0 0",
                         i, resValid, illegalOp, resData, resZero, branchTaken);
            end
            tick();
        end
        handshake();
        checks++;
        if ({resValid, illegalOp} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL illegal_clear: got val=%b ill=%b expected 0 0", resValid, illegalOp);
        end
`else
        checks++;
        if ({resValid, aluCtr} !== {1'b0, 4'b1111}) begin
            errors++;
            $display("[TB] FAIL illegal_ctr: got val=%b ctr=%b expected 0 1111", resValid, aluCtr);
        end
        tick();
        checks++;
        if ({resValid, resData, resZero, illegalOp} !== {1'b1, 32'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("[TB] FAIL illegal_result: got val=%b data=%h z=%b ill=%b expected 1 0 1 0",
                     resValid, resData, resZero, illegalOp);
        end
        handshake();
`endif
    endtask

    task automatic test_random();
        logic [5:0]  legal [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        logic [1:0]  op;
        logic [5:0]  fn;
        logic        br, bne, eZero, eTaken, eIll;
        logic [31:0] a, b, eRes;
        logic [3:0]  eCtr;
        for (int i = 0; i < 60; i++) begin
            op  = 2'($urandom_range(0, 3));
            fn  = ($urandom_range(0, 5) == 0) ? 6'($urandom) : legal[$urandom_range(0, 5)];
            br  = ($urandom_range(0, 3) == 0);
            bne = 1'($urandom);
            a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
            ref_model(op, fn, br, bne, a, b, eRes, eZero, eTaken, eIll, eCtr);
            drive_req(op, fn, br, bne, a, b);
            #1;
            checks++;
            if (reqReady !== 1'b1) begin
                errors++;
                $display("[TB] FAIL rand%0d_ready: got %b expected 1", i, reqReady);
            end
            tick();
            reqValid = 1'b0;
            resReady = 1'b0;
            if (!eIll) begin
                checks++;
                if ({resValid, aluCtr, aluIn1, aluIn2} !== {1'b0, eCtr, a, b}) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_issue: got val=%b ctr=%b in1=%h in2=%h expected 0 %b %h %h",
                             i, resValid, aluCtr, aluIn1, aluIn2, eCtr, a, b);
                end
                tick();
            end
            for (int s = $urandom_range(0, 2); s >= 0; s--) begin
                checks++;
                if ({resValid, resData, resZero, branchTaken, illegalOp} !== {1'b1, eRes, eZero, eTaken, eIll}) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_result: got val=%b data=%h z=%b bt=%b ill=%b expected 1 %h %b %b %b",
                             i, resValid, resData, resZero, branchTaken, illegalOp, eRes, eZero, eTaken, eIll);
                end
                if (s > 0) tick();
            end
            resReady = 1'b1;
            // Either drain to IDLE or leave resReady high so the next request
            // is accepted on the same edge as this response.
            if (i == 59 || $urandom_range(0, 1) == 0) begin
                tick();
                resReady = 1'b0;
                checks++;
                if (resValid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL rand%0d_drain: got val=%b expected 0", i, resValid);
                end
            end
        end
    endtask

    initial begin
        #1;
        test_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();
        test_rtype_add();
        test_slt();
        test_branch();
        test_backpressure();
        test_reset_mid();
        test_illegal();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
